// File: rtl/hazard_unit.sv
// Hazard detection, forwarding selects, stall/flush generation and the
// multi-cycle divide sequencer for the 5-stage MIPS core.
module hazard_unit #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       jrD,
  input  logic       divE,
  input  logic       i_stall,
  input  logic       d_stall,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       div_start,
  output logic       div_busy,
  output logic       div_done
);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  div_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic lwstall;
  logic brstall;
  logic divstall;

  // Register $0 never produces a hazard, so every match ignores it.
  function automatic logic hit(input logic en, input logic [4:0] dst, input logic [4:0] src);
    return en && (dst != 5'd0) && (dst == src);
  endfunction

  // Counter reaches zero on the same edge that moves BUSY into DONE,
  // so the front end sees one IDLE cycle plus DIV_CYCLES-1 BUSY cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (divE) begin
            state <= DIV_BUSY;
            cnt   <= CNT_W'(DIV_CYCLES - 1);
          end
        end
        DIV_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (!d_stall) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    stallW    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    flushW    = 1'b0;
    div_start = 1'b0;
    div_busy  = 1'b0;
    div_done  = 1'b0;
    lwstall   = 1'b0;
    brstall   = 1'b0;
    divstall  = 1'b0;

    if (!rst) begin
      if (hit(regwriteM, writeregM, rsE))      forwardAE = 2'b10;
      else if (hit(regwriteW, writeregW, rsE)) forwardAE = 2'b01;
      if (hit(regwriteM, writeregM, rtE))      forwardBE = 2'b10;
      else if (hit(regwriteW, writeregW, rtE)) forwardBE = 2'b01;

      forwardAD = hit(regwriteM, writeregM, rsD);
      forwardBD = hit(regwriteM, writeregM, rtD);

      lwstall = memtoregE && (hit(regwriteE, writeregE, rsD) || hit(regwriteE, writeregE, rtD));

      // jr only reads rs; a conditional branch compares both operands.
      brstall = (branchD || jrD) &&
                (hit(regwriteE, writeregE, rsD) ||
                 (branchD && hit(regwriteE, writeregE, rtD)) ||
                 hit(memtoregM, writeregM, rsD) ||
                 (branchD && hit(memtoregM, writeregM, rtD)));

      divstall  = ((state == DIV_IDLE) && divE) || (state == DIV_BUSY);
      div_start = (state == DIV_IDLE) && divE;
      div_busy  = (state == DIV_BUSY);
      div_done  = (state == DIV_DONE);

      if (d_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        stallW = 1'b1;
      end else if (divstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (lwstall || brstall || i_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a cycle-level reference model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_hazard_unit;

  localparam int DIV_CYCLES = 4;
  localparam int CNT_W      = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, jrD, divE, i_stall, d_stall;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushE, flushM, flushW;
  logic       div_start, div_busy, div_done;

  int total = 0;
  int bad   = 0;

  // Reference divider: remaining busy cycles and whether the result is pending.
  int busy_left = 0;
  bit in_done   = 1'b0;

  bit       run_compare = 1'b0;
  bit [4:0] stall_vec;

  hazard_unit #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jrD(jrD), .divE(divE),
    .i_stall(i_stall), .d_stall(d_stall),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_start(div_start), .div_busy(div_busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  assign stall_vec = {stallF, stallD, stallE, stallM, stallW};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (regwriteM && writeregM != 0 && writeregM == src) return 2'b10;
    if (regwriteW && writeregW != 0 && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit d_reads(input logic [4:0] dst, input bit both);
    return dst != 0 && (dst == rsD || (both && dst == rtD));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      busy_left = 0;
      in_done   = 1'b0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) in_done = 1'b1;
    end else if (in_done) begin
      if (!d_stall) in_done = 1'b0;
    end else if (divE) begin
      busy_left = DIV_CYCLES - 1;
    end
  end

  // Every cycle, rebuild all outputs from the hazard rules and compare.
  always @(negedge clk) begin
    logic [16:0] exp_v, act_v;
    bit idle, dstall_div, lw, br;
    bit [4:0] stalls;
    bit [2:0] flushes;
    exp_v = '0;
    if (run_compare && !rst) begin
      idle       = (busy_left == 0) && !in_done;
      dstall_div = (idle && divE) || (busy_left > 0);
      lw = memtoregE && regwriteE && d_reads(writeregE, 1'b1);
      br = (branchD || jrD) &&
           ((regwriteE && d_reads(writeregE, branchD)) || (memtoregM && d_reads(writeregM, branchD)));
      stalls  = 5'b00000;
      flushes = 3'b000;
      if (d_stall)                    stalls = 5'b11111;
      else if (dstall_div)            begin stalls = 5'b11100; flushes = 3'b010; end
      else if (lw || br || i_stall)   begin stalls = 5'b11000; flushes = 3'b100; end
      exp_v = {regwriteM && writeregM != 0 && writeregM == rsD,
               regwriteM && writeregM != 0 && writeregM == rtD,
               fwd_sel(rsE), fwd_sel(rtE), stalls, flushes,
               idle && divE, busy_left > 0, in_done};
    end
    act_v = {forwardAD, forwardBD, forwardAE, forwardBE,
             stallF, stallD, stallE, stallM, stallW,
             flushE, flushM, flushW, div_start, div_busy, div_done};
    if (run_compare) check_output("model_outputs", 32'(act_v), 32'(exp_v));
  end

  task automatic clear_inputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
    {branchD, jrD, divE, i_stall, d_stall} = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Directed divide sequences: per-cycle inputs and expected outputs.
  bit       seq_div   [8];
  bit       seq_ds    [8];
  bit [4:0] seq_stall [8];
  bit       seq_start [8];
  bit       seq_done  [8];

  initial begin
    clear_inputs();
    rst = 1'b1;
    d_stall = 1'b1;
    divE = 1'b1;
    run_compare = 1'b1;
    @(negedge clk);
    check_output("reset_stalls", 32'(stall_vec), 32'h0);
    check_output("reset_div_start", 32'(div_start), 32'h0);

    // Forwarding priority and $0 suppression
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    writeregM = 5'd8; regwriteM = 1'b1; writeregW = 5'd8; regwriteW = 1'b1; rsE = 5'd8;
    @(negedge clk);
    check_output("fwdAE_mem", 32'(forwardAE), 32'h2);
    next_cycle();
    regwriteM = 1'b0; rtE = 5'd8;
    @(negedge clk);
    check_output("fwdAE_wb", 32'(forwardAE), 32'h1);
    check_output("fwdBE_wb", 32'(forwardBE), 32'h1);
    next_cycle();
    regwriteM = 1'b1; writeregM = 5'd0; rsE = 5'd0;
    @(negedge clk);
    check_output("fwdAE_zero", 32'(forwardAE), 32'h0);

    // Load-use
    next_cycle();
    clear_inputs();
    memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd9; rtD = 5'd9;
    @(negedge clk);
    check_output("lw_stall", 32'({stallF, stallD, flushE, stallE}), 32'hE);
    next_cycle();
    writeregE = 5'd0;
    @(negedge clk);
    check_output("lw_zero_reg", 32'({stallF, stallD, flushE}), 32'h0);

    // Branch hazards
    next_cycle();
    clear_inputs();
    branchD = 1'b1; rsD = 5'd5; regwriteE = 1'b1; writeregE = 5'd5;
    @(negedge clk);
    check_output("br_stall", 32'({stallD, flushE}), 32'h3);
    next_cycle();
    regwriteE = 1'b0; writeregE = 5'd0; writeregM = 5'd5; regwriteM = 1'b1;
    @(negedge clk);
    check_output("br_fwd_stall", 32'(stallD), 32'h0);
    check_output("br_fwdAD", 32'(forwardAD), 32'h1);
    next_cycle();
    clear_inputs();
    jrD = 1'b1; rtD = 5'd6; regwriteE = 1'b1; writeregE = 5'd6;
    @(negedge clk);
    check_output("jr_ignores_rt", 32'(stallD), 32'h0);
    next_cycle();
    clear_inputs();
    branchD = 1'b1; rtD = 5'd7; memtoregM = 1'b1; writeregM = 5'd7;
    @(negedge clk);
    check_output("br_load_in_m", 32'({stallD, flushE}), 32'h3);
    next_cycle();
    clear_inputs();
    i_stall = 1'b1;
    @(negedge clk);
    check_output("istall", 32'({stall_vec, flushE}), 32'h31);

    // Plain divide: IDLE + 3 BUSY stall cycles, one DONE cycle, then IDLE
    seq_div   = '{1, 1, 1, 1, 1, 0, 0, 0};
    seq_ds    = '{0, 0, 0, 0, 0, 0, 0, 0};
    seq_stall = '{5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    seq_start = '{1, 0, 0, 0, 0, 0, 0, 0};
    seq_done  = '{0, 0, 0, 0, 1, 0, 0, 0};
    next_cycle();
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      divE = seq_div[c];
      d_stall = seq_ds[c];
      @(negedge clk);
      check_output($sformatf("div_stall_c%0d", c), 32'(stall_vec), 32'(seq_stall[c]));
      check_output($sformatf("div_start_c%0d", c), 32'(div_start), 32'(seq_start[c]));
      check_output($sformatf("div_done_c%0d", c), 32'(div_done), 32'(seq_done[c]));
      next_cycle();
    end

    // d_stall straddling BUSY->DONE holds DONE until it drops
    seq_div   = '{1, 1, 1, 1, 1, 1, 1, 0};
    seq_ds    = '{0, 0, 0, 1, 1, 1, 0, 0};
    seq_stall = '{5'b11100, 5'b11100, 5'b11100, 5'b11111, 5'b11111, 5'b11111, 5'b00000, 5'b00000};
    seq_done  = '{0, 0, 0, 0, 1, 1, 1, 0};
    for (int c = 0; c < 8; c++) begin
      divE = seq_div[c];
      d_stall = seq_ds[c];
      @(negedge clk);
      check_output($sformatf("dsd_stall_c%0d", c), 32'(stall_vec), 32'(seq_stall[c]));
      check_output($sformatf("dsd_done_c%0d", c), 32'(div_done), 32'(seq_done[c]));
      next_cycle();
    end

    // Reset mid-divide abandons the operation
    clear_inputs();
    divE = 1'b1;
    @(negedge clk);
    check_output("rdiv_start", 32'(div_start), 32'h1);
    next_cycle();
    @(negedge clk);
    check_output("rdiv_busy", 32'(div_busy), 32'h1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_output("rdiv_in_reset", 32'({stall_vec, flushM, div_busy}), 32'h0);
    next_cycle();
    rst = 1'b0;
    divE = 1'b0;
    @(negedge clk);
    check_output("rdiv_idle", 32'({div_busy, div_done, stallE}), 32'h0);
    next_cycle();
    @(negedge clk);
    check_output("rdiv_stays_idle", 32'({div_busy, div_done, stallE}), 32'h0);

    next_cycle();
    run_compare = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS SRAM-SoC core.
- Sits upstream of the per-stage pipeline registers and the stage controller.
- Generates every stall/flush strobe the controller and datapath consume (stallE/flushE/stallM/flushM/stallW/flushW, plus stallF/stallD).
- Also produces forwarding selects, and owns the multi-cycle divide sequencer FSM that freezes the front end while div/divu executes.

Parameters:
- DIV_CYCLES, 32, cycles the divider needs from start to result valid (>=2).
- CNT_W, 6, width of the divide cycle counter (must hold DIV_CYCLES-1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rsD, rtD  in  5 each  decode-stage source registers.
- rsE, rtE  in  5 each  execute-stage source registers.
- writeregE, writeregM, writeregW  in  5 each  destination register per stage.
- regwriteE, regwriteM, regwriteW  in  1 each  register-write enable per stage.
- memtoregE, memtoregM  in  1 each  load in E / load in M.
- branchD  in  1  conditional branch in decode (compare in D).
- jrD  in  1  jr/jalr in decode (reads rsD in D).
- divE  in  1  div/divu in execute.
- i_stall  in  1  instruction SRAM wait (fetch data not ready).
- d_stall  in  1  data SRAM wait (M-stage access not complete).
- forwardAD, forwardBD  out  1 each  D-stage compare operand from M-stage ALU result.
- forwardAE, forwardBE  out  2 each  E operand select: 00 regfile, 01 W result, 10 M result.
- stallF, stallD, stallE, stallM, stallW  out  1 each  hold stage register.
- flushE, flushM, flushW  out  1 each  clear stage register (insert bubble).
- div_start  out  1  one-cycle pulse launching the divider.
- div_busy  out  1  high in DIV_BUSY.
- div_done  out  1  high in DIV_DONE (hilo write allowed).

Behaviour:
- Reset: while rst=1, all outputs are 0 and state is DIV_IDLE with cnt=0. Reset mid-divide abandons the operation; the unit is in DIV_IDLE after the edge.
- Register $0 is never a hazard source: every match below also requires writereg!=0.
- forwardAE: 10 if regwriteM && writeregM==rsE; else 01 if regwriteW && writeregW==rsE; else 00. M has priority over W. forwardBE is the same using rtE.
- forwardAD = regwriteM && writeregM==rsD. forwardBD is the same using rtD.
- lwstall: memtoregE && regwriteE && writeregE matches rsD or rtD.
- brstall: (branchD || jrD) and either:
  - regwriteE && writeregE matches rsD, or matches rtD (rtD only when branchD); or
  - memtoregM && writeregM matches the same operand(s).
- Divide FSM:
  - DIV_IDLE: if divE, go to DIV_BUSY, pulse div_start, load cnt=DIV_CYCLES-1.
  - DIV_BUSY: cnt decrements every cycle, including under d_stall. At cnt==0 go to DIV_DONE.
  - DIV_DONE: lasts exactly one cycle unless d_stall=1, in which case hold DIV_DONE until d_stall=0, then go to DIV_IDLE.
  - A divE seen in DIV_DONE does not retrigger, because E advances that cycle.
- divstall = (state==DIV_IDLE && divE) || state==DIV_BUSY.
- Stall/flush priority, highest first; exactly one case applies:
  1. d_stall: stallF=stallD=stallE=stallM=stallW=1; all flushes 0.
  2. divstall: stallF=stallD=stallE=1; flushM=1 (bubble into M).
  3. lwstall or brstall: stallF=stallD=1; flushE=1.
  4. i_stall: stallF=stallD=1; flushE=1.
  5. None of the above: all stalls and flushes 0.
- flushW is reserved and always 0 in this revision.
- Latency: all stall/forward outputs are combinational from the inputs and current FSM state (same cycle). FSM state is registered.

Test Plan:
- Forwarding: writeregM=8, regwriteM=1, writeregW=8, regwriteW=1, rsE=8 -> forwardAE=10. Drop regwriteM -> forwardAE=01. writeregM=0 with rsE=0 -> forwardAE=00.
- Load-use: memtoregE=1, regwriteE=1, writeregE=9, rtD=9 -> stallF=stallD=flushE=1, stallE=0. Same stimulus with writeregE=0 -> no stall.
- Branch hazard: branchD=1, rsD=5, regwriteE=1, writeregE=5, memtoregE=0 -> stallD=flushE=1. Next cycle with writeregM=5, regwriteM=1, memtoregM=0 -> no stall, forwardAD=1.
- Divide, DIV_CYCLES=4: divE=1 in IDLE -> div_start for 1 cycle; stallE=flushM=1 for 4 cycles (IDLE+3 BUSY); div_done=1 on cycle 5 with stalls low; then IDLE.
- d_stall during divide: assert d_stall across the BUSY->DONE edge for 3 cycles -> all five stalls=1, div_done held high until d_stall drops, then IDLE next cycle.
- Reset mid-divide: rst=1 in BUSY with cnt=2 -> next cycle div_busy=0, all outputs 0. After rst drops with divE=0, FSM stays in DIV_IDLE.
